// File: rtl/sram_read_arbiter_if.sv
// Bundles the requester-side and SRAM-side signals of the shared SRAM read port.
// The arbiter attaches through the slave modport; the driving environment uses master.
interface sram_read_arbiter_if #(
   parameter int NREQ = 3,
   parameter int AW   = 20,
   parameter int DW   = 16
);
   logic [NREQ-1:0]    i_req;
   logic [NREQ*AW-1:0] i_addr;
   logic [NREQ-1:0]    o_gnt;
   logic [DW-1:0]      o_rdata;
   logic [NREQ-1:0]    o_rvalid;
   logic [AW-1:0]      o_sram_addr;
   logic               o_sram_rd;
   logic [DW-1:0]      i_sram_data;

   modport slave (
      input  i_req, i_addr, i_sram_data,
      output o_gnt, o_rdata, o_rvalid, o_sram_addr, o_sram_rd
   );

   modport master (
      output i_req, i_addr, i_sram_data,
      input  o_gnt, o_rdata, o_rvalid, o_sram_addr, o_sram_rd
   );
endinterface

// File: rtl/sram_read_arbiter.sv
// Shares one fixed-latency SRAM read port between NREQ requesters: requester 0 has
// fixed priority, the rest are round-robin; read data is routed back by a tag pipeline.
module sram_read_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 20,
   parameter int DW   = 16,
   parameter int LAT  = 2
) (
   input  logic                i_clk,
   input  logic                i_rst,
   sram_read_arbiter_if.slave  io_bus
);

   localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   r_rr_ptr;
   logic [NREQ-1:0] r_gnt;
   logic [NREQ-1:0] r_rvalid;
   logic [DW-1:0]   r_rdata;
   logic [AW-1:0]   r_sram_addr;
   logic            r_sram_rd;
   logic [NREQ-1:0] r_tag_p [LAT];

   logic [NREQ-1:0] w_elig;
   logic            w_win_vld;
   logic [PW-1:0]   w_win_idx;
   logic [NREQ-1:0] w_gnt_nxt;
   logic [AW-1:0]   w_win_addr;
   logic [PW-1:0]   w_rr_nxt;

   // A requester granted last edge still holds its old request; mask it for one edge.
   assign w_elig = io_bus.i_req & ~r_gnt;

   always_comb begin
      int k;
      w_win_vld = 1'b0;
      w_win_idx = '0;
      k         = 0;
      if (w_elig[0]) begin
         w_win_vld = 1'b1;
      end else begin
         for (int i = 0; i < NREQ-1; i++) begin
            k = int'(r_rr_ptr) + i;
            if (k > NREQ-1) k = k - (NREQ-1);
            if (!w_win_vld && w_elig[k]) begin
               w_win_vld = 1'b1;
               w_win_idx = PW'(k);
            end
         end
      end
   end

   assign w_gnt_nxt  = w_win_vld ? (NREQ'(1) << w_win_idx) : '0;
   assign w_win_addr = io_bus.i_addr[int'(w_win_idx)*AW +: AW];

   always_comb begin
      w_rr_nxt = r_rr_ptr;
      if (w_win_vld && (w_win_idx != '0)) begin
         w_rr_nxt = (int'(w_win_idx) == NREQ-1) ? PW'(1) : w_win_idx + PW'(1);
      end
   end

   // ---- issue stage: grant, SRAM address, tag push ----
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_gnt       <= '0;
         r_sram_rd   <= 1'b0;
         r_sram_addr <= '0;
         r_rr_ptr    <= PW'(1);
      end else begin
         r_gnt     <= w_gnt_nxt;
         r_sram_rd <= w_win_vld;
         r_rr_ptr  <= w_rr_nxt;
         if (w_win_vld) r_sram_addr <= w_win_addr;
      end
   end

   // ---- tag pipeline: stage LAT-1 lines up with the data the SRAM presents next edge ----
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < LAT; i++) r_tag_p[i] <= '0;
      end else begin
         r_tag_p[0] <= w_gnt_nxt;
         for (int i = 1; i < LAT; i++) r_tag_p[i] <= r_tag_p[i-1];
      end
   end

   // ---- return stage: capture SRAM data and flag its owner ----
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rvalid <= '0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= r_tag_p[LAT-1];
         if (|r_tag_p[LAT-1]) r_rdata <= io_bus.i_sram_data;
      end
   end

   assign io_bus.o_gnt       = r_gnt;
   assign io_bus.o_rvalid    = r_rvalid;
   assign io_bus.o_rdata     = r_rdata;
   assign io_bus.o_sram_addr = r_sram_addr;
   assign io_bus.o_sram_rd   = r_sram_rd;

endmodule
